// File: rtl/uart_fifo_tx.sv
// UART transmit path: circular input FIFO feeding a frame serializer.
// Frames leave back-to-back while words are queued.
module uart_fifo_tx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BIT_RATE   = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          tx
);

  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;

  localparam logic [CW-1:0] CNT_MAX   = CW'(CPB - 1);
  localparam logic [LW-1:0] FULL      = LW'(FIFO_DEPTH);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [3:0]            bit_q;
  logic                  stop_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic                  par_q;
  logic                  tx_q;

  logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wptr_q;
  logic [AW-1:0]         rptr_q;
  logic [LW-1:0]         level_q;
  logic [LW-1:0]         level_d;

  logic                  fifo_ne;
  logic                  bit_end;
  logic                  last_stop;
  logic                  push;
  logic                  pop;
  logic [DATA_BITS-1:0]  head;
  logic                  par_d;

  assign fifo_ne   = (level_q != '0);
  assign bit_end   = (cnt_q == CNT_MAX);
  assign last_stop = (state_q == S_STOP) && bit_end
                   && (stop_q == LAST_STOP);
  assign wr_ready  = (level_q != FULL);
  assign push      = wr_valid && wr_ready;
  assign pop       = fifo_ne
                   && ((state_q == S_IDLE) || last_stop);
  assign head      = mem_q[rptr_q];
  assign par_d     = (PARITY == 1) ? ~^head : ^head;

  assign fifo_level = level_q;
  assign busy       = (state_q != S_IDLE) || fifo_ne;
  assign tx         = tx_q;

  always_comb begin
    level_d = level_q;
    unique case (1'b1)
      push && !pop: level_d = level_q + 1'b1;
      pop && !push: level_d = level_q - 1'b1;
      default:      level_d = level_q;
    endcase
  end

  // Storage carries no reset; clearing the pointers discards it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (pop) begin
            state_q <= S_START;
            shift_q <= head;
            par_q   <= par_d;
            tx_q    <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= S_DATA;
            tx_q    <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == LAST_DATA) begin
              stop_q <= 1'b0;
              if (PARITY != 0) begin
                state_q <= S_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            stop_q  <= 1'b0;
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (stop_q == LAST_STOP) begin
              // Chain straight into the next start bit when queued.
              if (pop) begin
                state_q <= S_START;
                shift_q <= head;
                par_q   <= par_d;
                tx_q    <= 1'b0;
              end else begin
                state_q <= S_IDLE;
                tx_q    <= 1'b1;
              end
            end else begin
              stop_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule
